regfile_dump_uart: RTL



---
 rtl/regfile_dump_uart_if.sv | 13 +
 rtl/regfile_dump_uart.sv | 116 +++++++++++
 2 files changed

// File: rtl/regfile_dump_uart_if.sv
// Handshake and data signals between the dump engine and its host/register file.
// master = the dump engine, slave = the host side that drives start and rd_data.
interface regfile_dump_uart_if;
  logic        start;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;
  logic        tx;
  logic        busy;
  logic        done;

  modport master (input start, rd_data, output rd_addr, tx, busy, done);
  modport slave  (output start, rd_data, input rd_addr, tx, busy, done);
endinterface

// File: rtl/regfile_dump_uart.sv
// Register-file dump engine: on start, sends a sync byte then every register
// FIRST_REG..LAST_REG as four little-endian 8N1 UART frames.
module regfile_dump_uart #(
  parameter int         CLKS_PER_BIT = 434,
  parameter int         FIRST_REG    = 0,
  parameter int         LAST_REG     = 31,
  parameter logic [7:0] SYNC_BYTE    = 8'hA5
) (
  input  logic                clk,
  input  logic                reset,
  regfile_dump_uart_if.master bus
);
  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST  = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [4:0]        FIRST_ADDR = 5'(FIRST_REG);
  localparam logic [4:0]        LAST_ADDR  = 5'(LAST_REG);

  typedef enum logic [2:0] {IDLE, SYNC, ADDR, LATCH, SEND, DONE} state_t;

  state_t            state_q;
  logic              tx_q;
  logic              busy_q;
  logic              done_q;
  logic [4:0]        rd_addr_q;
  logic [BAUD_W-1:0] baud_q;
  logic [3:0]        bit_q;
  logic [1:0]        byte_q;
  logic [31:0]       shift_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rd_addr_q <= FIRST_ADDR;
      baud_q    <= '0;
      bit_q     <= '0;
      byte_q    <= '0;
      shift_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          rd_addr_q <= FIRST_ADDR;
          tx_q      <= 1'b1;
          if (bus.start) begin
            state_q <= SYNC;
            busy_q  <= 1'b1;
            tx_q    <= 1'b0;
            shift_q <= {24'h0, SYNC_BYTE};
            baud_q  <= '0;
            bit_q   <= '0;
            byte_q  <= '0;
          end
        end
        SYNC, SEND: begin
          if (baud_q != BAUD_LAST) begin
            baud_q <= baud_q + 1'b1;
          end else begin
            baud_q <= '0;
            // bit_q names the bit currently on the line: 0 start, 1..8 data, 9 stop
            if (bit_q != 4'd9) begin
              bit_q <= bit_q + 4'd1;
              if (bit_q == 4'd8) begin
                tx_q <= 1'b1;
              end else begin
                tx_q    <= shift_q[0];
                shift_q <= {1'b0, shift_q[31:1]};
              end
            end else begin
              bit_q <= '0;
              if (state_q == SEND && byte_q != 2'd3) begin
                byte_q <= byte_q + 2'd1;
                tx_q   <= 1'b0;
              end else begin
                tx_q   <= 1'b1;
                byte_q <= '0;
                if (state_q == SYNC) begin
                  state_q <= ADDR;
                end else if (rd_addr_q < LAST_ADDR) begin
                  rd_addr_q <= rd_addr_q + 5'd1;
                  state_q   <= ADDR;
                end else begin
                  state_q <= DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                end
              end
            end
          end
        end
        ADDR: state_q <= LATCH;
        LATCH: begin
          // rd_data reflects rd_addr sampled on the edge that entered LATCH
          shift_q <= bus.rd_data;
          tx_q    <= 1'b0;
          baud_q  <= '0;
          bit_q   <= '0;
          byte_q  <= '0;
          state_q <= SEND;
        end
        DONE: begin
          state_q   <= IDLE;
          rd_addr_q <= FIRST_ADDR;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.tx      = tx_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.rd_addr = rd_addr_q;
endmodule
